// File: rtl/cla_slice_sequencer_if.sv
// rtl/cla_slice_sequencer_if.sv - operand/result handshake bundle for cla_slice_sequencer
// Carries the optional sub input only when CLA_SEQ_SUB_EN is defined.
interface cla_slice_sequencer_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CLA_SEQ_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
`ifdef CLA_SEQ_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
`ifdef CLA_SEQ_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/cla_slice_sequencer.sv
// rtl/cla_slice_sequencer.sv - WIDTH-bit adder applying one shared 4-bit CLA slice per cycle, LSB nibble first
// Optional macro CLA_SEQ_SUB_EN adds the sub input (a-b via ~b and forced carry-in).
module cla_slice_sequencer #(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  cla_slice_sequencer_if.slave bus
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("cla_slice_sequencer: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic [3:0] nib_a, nib_b, p, g, s_nib;
  logic       c1, c2, c3, c4;

  // Shared lookahead slice; b_q already holds ~b for subtraction.
  always_comb begin
    nib_a = a_q[4*idx_q +: 4];
    nib_b = b_q[4*idx_q +: 4];
    p     = nib_a ^ nib_b;
    g     = nib_a & nib_b;
    c1    = g[0] | (p[0] & carry_q);
    c2    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c3    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
    c4    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (&p & carry_q);
    s_nib = p ^ {c3, c2, c1, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
`ifdef CLA_SEQ_SUB_EN
          if (bus.sub) begin
            b_d     = ~bus.b;
            carry_d = 1'b1;
          end
`endif
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[4*idx_q +: 4] = s_nib;
        carry_d             = c4;
        idx_d               = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = c4;
          ovf_d   = c3 ^ c4;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_slice_sequencer.sv
// tb/tb_cla_slice_sequencer.sv - scoreboard bench for cla_slice_sequencer against an arithmetic reference
// Sub cases run only when CLA_SEQ_SUB_EN is defined.
module tb_cla_slice_sequencer;
  localparam int W  = 16;
  localparam int NS = W / 4;

  logic clk = 1'b0;
  logic rst;
  logic sub_v;
  logic fin = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cla_slice_sequencer_if #(.WIDTH(W)) bus ();
`ifdef CLA_SEQ_SUB_EN
  assign bus.sub = sub_v;
`endif

  cla_slice_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic c, input logic s);
    exp_t       e;
    logic [W:0] full;
    if (s) full = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
    else   full = {1'b0, av} + {1'b0, bv} + (W+1)'(c);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    if (s) e.ovf = (av[W-1] != bv[W-1]) && (e.sum[W-1] != av[W-1]);
    else   e.ovf = (av[W-1] == bv[W-1]) && (e.sum[W-1] != av[W-1]);
    e.acc  = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // All checking lives here, sampled on the falling edge.
  logic         prev_ov = 1'b0, prev_or = 1'b0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_cout = 1'b0, prev_ovf = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    logic s_eff;
    if (rst) begin
      chk("reset_state", {bus.sum, bus.cout, bus.ovf, bus.out_valid, bus.busy, bus.in_ready}, 64'd0);
      sb.delete();
    end else begin
      if (prev_ov && prev_or)
        chk("after_handshake_valid_ready", {bus.out_valid, bus.in_ready}, 64'b01);
      if (bus.out_valid && !prev_ov) begin
        if (sb.size() == 0) chk("spurious_out_valid", 64'd1, 64'd0);
        else                chk("latency", 64'(cyc - sb[0].acc), 64'(NS));
      end
      if (bus.out_valid && prev_ov && !prev_or)
        chk("hold_stable", {bus.sum, bus.cout, bus.ovf}, {prev_sum, prev_cout, prev_ovf});
      if (bus.out_valid)
        chk("done_ready_busy", {bus.in_ready, bus.busy}, 64'b01);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) chk("result_unexpected", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          chk("result", {bus.sum, bus.cout, bus.ovf}, {e.sum, e.cout, e.ovf});
        end
      end
      if (bus.in_valid && bus.in_ready) begin
`ifdef CLA_SEQ_SUB_EN
        s_eff = bus.sub;
`else
        s_eff = 1'b0;
`endif
        e = model(bus.a, bus.b, bus.cin, s_eff);
        e.acc = cyc + 1;
        sb.push_back(e);
      end
      if (fin) begin
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    end
    prev_ov   <= bus.out_valid;
    prev_or   <= bus.out_ready;
    prev_sum  <= bus.sum;
    prev_cout <= bus.cout;
    prev_ovf  <= bus.ovf;
  end

  task automatic timeout(input string w);
    $display("FAIL timeout_%s: got no event within 50 cycles, required one", w);
    $fatal(1, "bench aborted");
  endtask

  task automatic scramble();
    bus.a   = W'($urandom);
    bus.b   = W'($urandom);
    bus.cin = 1'($urandom);
    sub_v   = 1'($urandom);
  endtask

  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c, input logic s);
    int k;
    @(posedge clk); #2;
    bus.a = av; bus.b = bv; bus.cin = c; sub_v = s; bus.in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready) begin
      k++;
      if (k > 50) timeout("accept");
      @(negedge clk);
    end
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    scramble();
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c,
                       input logic s, input int hold);
    int k;
    accept(av, bv, c, s);
    k = 0;
    @(negedge clk);
    while (!bus.out_valid) begin
      k++;
      if (k > 50) timeout("out_valid");
      @(negedge clk);
    end
    repeat (hold) @(negedge clk);
    @(posedge clk); #2; bus.out_ready = 1'b1;
    @(posedge clk); #2; bus.out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0; sub_v = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 0);
    do_op(16'hBEEF, 16'h1111, 1'b0, 1'b0, 3);

    // in_valid stays high with fresh operands every cycle
    @(posedge clk); #2 bus.out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom); sub_v = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #2;
    end
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 bus.out_ready = 1'b0;

    // Abort two edges after accept; no result may appear
    accept(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0; bus.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #2 bus.out_ready = 1'b0;
    do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0);

`ifdef CLA_SEQ_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1);
`endif

    for (int i = 0; i < 24; i++) begin
`ifdef CLA_SEQ_SUB_EN
      do_op(pick(), pick(), 1'($urandom), 1'($urandom), $urandom_range(0, 2));
`else
      do_op(pick(), pick(), 1'($urandom), 1'b0, $urandom_range(0, 2));
`endif
    end

    repeat (3) @(posedge clk);
    #2 fin = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish within 200000 ns, required finish");
    $fatal(1, "bench aborted");
  end
endmodule

// File: doc/cla_slice_sequencer.md
Name: cla_slice_sequencer

Overview:
Multi-cycle wide adder built around a single shared 4-bit carry-lookahead slice (per-bit P = a^b, G = a&b, lookahead carries C1..C4). Accepts WIDTH-bit operands over a valid/ready handshake and applies the slice to one nibble per cycle, LSB first, with the slice carry-out registered into the next nibble's carry-in. Result leaves through a valid/ready output handshake. Sits between the operand register file and the result bus wherever a full-width CLA tree costs too much area.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and >= 4 (elaboration error otherwise)
NSLICE, WIDTH/4, derived; nibble count; not overridable

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands and cin valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to nibble 0
out_valid  output  1  sum/cout/ovf valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
busy  output  1  high in RUN or DONE

Behaviour:
- One clock domain. rst asynchronous, active-high; acts immediately, no clock required.
- Reset values: state=IDLE, sum=0, cout=0, ovf=0, out_valid=0, busy=0, slice index=0, carry reg=0. in_ready=0 while rst is high, 1 from the first cycle after release.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On clk edge with in_valid&in_ready: latch a, b; carry reg <= cin; idx <= 0; sum <= 0; go RUN. in_valid low: remain IDLE, hold prior sum/cout/ovf.
- RUN: in_ready=0, busy=1. Each cycle the slice takes a[4*idx+:4], b[4*idx+:4], carry reg. Results use lookahead equations, not ripple. Each edge: sum[4*idx+:4] <= slice sum; carry reg <= C4; idx <= idx+1. When idx==NSLICE-1: cout <= C4; ovf <= C3^C4 of that nibble; go DONE.
- DONE: out_valid=1, in_ready=0, busy=1. sum/cout/ovf are stable while out_valid=1 and out_ready=0. Edge with out_ready=1: out_valid <= 0; go IDLE. sum/cout/ovf hold until the next accept.
- Latency: out_valid rises exactly NSLICE edges after the accepting edge (WIDTH=16: 4 cycles). Throughput: at most one op per NSLICE+2 cycles.
- No accept in the cycle out_valid falls; in_ready reasserts the following cycle (IDLE).
- Inputs a, b, cin are ignored outside the accepting edge. Changes during RUN have no effect.
- out_ready is ignored outside DONE.
- NSLICE=1: RUN lasts exactly one cycle.
- rst mid-RUN or mid-DONE: the operation is aborted and discarded. All outputs return to reset values. No partial result is ever presented.
- Arithmetic is modulo 2^WIDTH. The cout and ovf definitions hold for every WIDTH.

Optional Feature:
Macro CLA_SEQ_SUB_EN.
- Defined: extra port sub (input, 1), sampled only on the accepting edge. sub=1 latches ~b and forces carry reg to 1, ignoring cin, so the result is a-b. cout=1 means no borrow. ovf is signed-subtract overflow. sub=0 behaves exactly as in the undefined build.
- Undefined: no sub port; add only; identical timing in both builds.

Test Plan:
1. WIDTH=16, a=0xFFFF, b=0x0001, cin=0 -> out_valid exactly 4 cycles after accept; sum=0x0000, cout=1, ovf=0.
2. a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
3. Backpressure: result ready, out_ready held low 3 cycles -> out_valid, sum, cout stay constant and in_ready=0. out_ready=1 -> out_valid drops next edge; in_ready=1 one cycle later.
4. in_valid held high continuously with new operands every cycle during RUN -> only the first operand set is used; the next accept happens only after returning to IDLE.
5. rst pulsed 2 cycles after accept (a=0xAAAA, b=0x5555) -> immediate return to reset values, out_valid never rises. A subsequent op 0x0003+0x0004 gives sum=0x0007.
6. With CLA_SEQ_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
